// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction at a time over req/gnt/rvalid,
// and presents it to decode with a valid/ready handshake. Branch redirects apply on accept.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            misalign,
    output logic [31:0]     fetch_count,
    output logic [1:0]      fsm_state
);

    // Handshakes: memory takes a request on a cycle with imem_req && imem_gnt, and the
    // response arrives on any later cycle with imem_rvalid; decode takes the presented
    // instruction on a cycle with instr_valid && instr_ready. Once raised, imem_req and
    // instr_valid stay high with stable payload until their handshake completes.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            misalign_q;
    logic [31:0]     count_q;
    logic            accept;

    assign accept = (state_q == S_HOLD) && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem_gnt)    state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
            S_HOLD:  if (instr_ready) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_REQ:   imem_req    = 1'b1;
            S_HOLD:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Redirect targets are forced word-aligned; a dropped offset is flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            misalign_q <= accept && pc_src && (pc_target[1:0] != 2'b00);
            if ((state_q == S_WAIT) && imem_rvalid) begin
                instr_q <= imem_rdata;
            end
            if (accept) begin
                pc_q    <= pc_src ? {pc_target[XLEN-1:2], 2'b00} : pc_plus4;
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign misalign    = misalign_q;
    assign fetch_count = count_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, a reset-during-fetch sequence,
// and randomized fetches checked against a transaction-level PC/count model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'd0;
    logic        misalign;
    logic [31:0] fetch_count;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    typedef struct {
        int          gd;
        int          rd;
        int          yd;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] data;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[6];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .misalign    (misalign),
        .fetch_count (fetch_count),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full fetch; the bench plays the memory and the core. Inputs change on negedge.
    task automatic do_fetch(input int gd, input int rd, input int yd, input logic src,
                            input logic [31:0] tgt, input logic [31:0] data,
                            input logic [31:0] exp_pc, input logic [31:0] exp_next,
                            input logic exp_mis, input logic [31:0] exp_cnt);
        int          n;
        logic [31:0] e;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, exp_pc);
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, exp_pc);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("req_drop", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rd; i++) begin
            @(negedge clk);
            chk("wait_noreq", {31'd0, imem_req}, 32'd0);
            chk("wait_novalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        exp_q.push_back(data);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        e = exp_q.pop_front();
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, e);
        chk("op", {25'd0, op}, {25'd0, e[6:0]});
        chk("pc", pc, exp_pc);
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < yd; i++) begin
            pc_src    = 1'($urandom_range(0, 1));
            pc_target = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
            chk("hold_instr", instr, e);
            chk("hold_pc", pc, exp_pc);
        end
        instr_ready = 1'b1;
        pc_src      = src;
        pc_target   = tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        pc_target   = $urandom;
        chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
        chk("fetch_count", fetch_count, exp_cnt);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, exp_next);
        @(negedge clk);
        chk("misalign_pulse", {31'd0, misalign}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_op"}, {25'd0, op}, 32'h13);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_cnt"}, fetch_count, 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 1'b0, 32'h0,         32'h0000_2083, 32'h0,         32'h4,         1'b0};
        vecs[1] = '{5, 3, 0, 1'b0, 32'h0,         32'h0050_0093, 32'h4,         32'h8,         1'b0};
        vecs[2] = '{0, 0, 4, 1'b1, 32'h100,       32'h0000_0033, 32'h8,         32'h100,       1'b0};
        vecs[3] = '{1, 1, 1, 1'b1, 32'h102,       32'h0000_0063, 32'h100,       32'h100,       1'b1};
        vecs[4] = '{0, 2, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_006F, 32'h100,       32'hFFFF_FFFC, 1'b1};
        vecs[5] = '{2, 0, 2, 1'b0, 32'h0,         32'h0000_0023, 32'hFFFF_FFFC, 32'h0,         1'b0};

        #12;
        check_reset_state("rst");
        @(negedge clk);
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        chk("idle_first", {30'd0, fsm_state}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i].gd, vecs[i].rd, vecs[i].yd, vecs[i].src, vecs[i].tgt,
                     vecs[i].data, vecs[i].exp_pc, vecs[i].exp_next, vecs[i].exp_mis,
                     32'(i + 1));
        end

        // Reset while waiting for a response, then deliver a stale rvalid.
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("pre_rst_wait", {30'd0, fsm_state}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_instr", instr, 32'h0000_0013);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h0);

        m_pc  = 32'h0;
        m_cnt = 32'd0;
        for (int i = 0; i < 150; i++) begin
            logic        src;
            logic [31:0] tgt;
            logic [31:0] nxt;
            src = 1'($urandom_range(0, 1));
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                              : $urandom;
            nxt = src ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     src, tgt, $urandom, m_pc, nxt, src && (tgt[1:0] != 2'b00), m_cnt);
            m_pc = nxt;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 500000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
